// File: rtl/kb_code_controller.sv
// PS/2 scan-code controller: make/break/extended FSM feeding a small ASCII FIFO.
// Optional KB_TYPEMATIC_FILTER_EN drops auto-repeat make codes of the held key.
module kb_code_controller #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_done_tick,
    output logic [7:0] key_code,
    input  logic [7:0] ascii_in,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_rd,
    output logic       overflow_tick
);
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam logic [7:0]  EXT_CODE   = 8'hE0;

    typedef enum logic [2:0] {IDLE, LOOKUP, BRK, EXT, EXT_BRK} state_t;

    state_t          state_q, state_d;
    logic [7:0]      key_code_q, key_code_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ascii_valid_q, ascii_valid_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [DEPTH];
    logic            push_c, pop_c, full_c, wr_c;
`ifdef KB_TYPEMATIC_FILTER_EN
    logic [7:0]      held_code_q, held_code_d;
`endif

    // Scan-code sequencing; push request raised at the end of LOOKUP
    always_comb begin
        state_d    = state_q;
        key_code_d = key_code_q;
        push_c     = 1'b0;
`ifdef KB_TYPEMATIC_FILTER_EN
        held_code_d = held_code_q;
`endif
        case (state_q)
            IDLE: begin
                if (scan_done_tick) begin
                    if (scan_code == BREAK_CODE) begin
                        state_d = BRK;
                    end else if (scan_code == EXT_CODE) begin
                        state_d = EXT;
                    end else begin
`ifdef KB_TYPEMATIC_FILTER_EN
                        if (scan_code != held_code_q) begin
                            key_code_d  = scan_code;
                            held_code_d = scan_code;
                            state_d     = LOOKUP;
                        end
`else
                        key_code_d = scan_code;
                        state_d    = LOOKUP;
`endif
                    end
                end
            end
            LOOKUP: begin
                state_d = IDLE;
                push_c  = (ascii_in != 8'h00);
            end
            BRK: begin
                if (scan_done_tick) begin
                    state_d = IDLE;
`ifdef KB_TYPEMATIC_FILTER_EN
                    if (scan_code == held_code_q) held_code_d = 8'h00;
`endif
                end
            end
            EXT: begin
                if (scan_done_tick) state_d = (scan_code == BREAK_CODE) ? EXT_BRK : IDLE;
            end
            EXT_BRK: begin
                if (scan_done_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; a simultaneous pop frees the slot for a push into a full queue
    always_comb begin
        pop_c      = ascii_rd && (count_q != CW'(0));
        full_c     = (count_q == CW'(DEPTH));
        wr_c       = push_c && (!full_c || pop_c);
        overflow_d = push_c && full_c && !pop_c;
        wr_ptr_d   = wr_c  ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({wr_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ascii_valid_d = (count_d != CW'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            key_code_q    <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ascii_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef KB_TYPEMATIC_FILTER_EN
            held_code_q   <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            key_code_q    <= key_code_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ascii_valid_q <= ascii_valid_d;
            overflow_q    <= overflow_d;
`ifdef KB_TYPEMATIC_FILTER_EN
            held_code_q   <= held_code_d;
`endif
        end
    end

    // Storage array needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (wr_c) mem_q[wr_ptr_q] <= ascii_in;
    end

    assign key_code      = key_code_q;
    assign ascii_out     = mem_q[rd_ptr_q];
    assign ascii_valid   = ascii_valid_q;
    assign overflow_tick = overflow_q;
endmodule
